// File: rtl/hist_pkg.sv
// Shared types and sizing helpers for the histogram accumulator.
package hist_pkg;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DUMP  = 2'd1,
        ST_CLEAR = 2'd2
    } hist_state_t;

    function automatic int unsigned num_bins(input int unsigned bin_bits);
        return 32'd1 << bin_bits;
    endfunction

    // Largest value a cnt_w-bit counter can hold (cnt_w < 32).
    function automatic int unsigned cnt_max(input int unsigned cnt_w);
        return (32'd1 << cnt_w) - 32'd1;
    endfunction

endpackage

// File: rtl/hist_bin_map.sv
// Maps a sample to its histogram bin (top BIN_BITS of the sample).
module hist_bin_map #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned BIN_BITS = 4
) (
    input  logic [DATA_W-1:0]   s_data,
    output logic [BIN_BITS-1:0] bin_c
);

    assign bin_c = s_data[DATA_W-1 -: BIN_BITS];

    // Low-order sample bits do not affect the bin in this mode.
    if (BIN_BITS < DATA_W) begin : g_low_bits
        logic unused_low;
        assign unused_low = ^s_data[DATA_W-BIN_BITS-1:0];
    end

endmodule

// File: rtl/hist_accum_engine.sv
// Histogram accumulator with sequential clear and backpressured dump.
// Optional peak tracker enabled by defining HIST_PEAK_EN.
module hist_accum_engine
    import hist_pkg::*;
#(
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned BIN_BITS      = 4,
    parameter int unsigned CNT_W         = 8,
    parameter bit          CLEAR_ON_READ = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    input  logic [DATA_W-1:0]   s_data,
    output logic                s_ready,
    input  logic                dump_req,
    input  logic                clr_req,
    output logic                m_valid,
    output logic [CNT_W-1:0]    m_data,
    output logic [BIN_BITS-1:0] m_bin,
    output logic                m_last,
    input  logic                m_ready,
    output logic                busy,
`ifdef HIST_PEAK_EN
    output logic [BIN_BITS-1:0] peak_bin,
    output logic [CNT_W-1:0]    peak_cnt,
`endif
    output logic                sat_flag
);

    localparam int unsigned       NUM_BINS = num_bins(BIN_BITS);
    localparam logic [BIN_BITS-1:0] LAST_IDX = BIN_BITS'(NUM_BINS - 1);
    localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(cnt_max(CNT_W));

    hist_state_t         state_q, state_d;
    logic [BIN_BITS-1:0] idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q [NUM_BINS];
    logic [CNT_W-1:0]    cnt_d [NUM_BINS];
    logic                sat_d;
    logic [BIN_BITS-1:0] bin_c;
    logic [CNT_W-1:0]    inc_c;
    logic                dump_d;
`ifdef HIST_PEAK_EN
    logic [BIN_BITS-1:0] peak_bin_d;
    logic [CNT_W-1:0]    peak_cnt_d;
`endif

    hist_bin_map #(
        .DATA_W   (DATA_W),
        .BIN_BITS (BIN_BITS)
    ) u_bin_map (
        .s_data (s_data),
        .bin_c  (bin_c)
    );

    // Next-state, counter read/modify/write and flag update.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        sat_d   = sat_flag;
        inc_c   = cnt_q[bin_c] + CNT_W'(1);
`ifdef HIST_PEAK_EN
        peak_bin_d = peak_bin;
        peak_cnt_d = peak_cnt;
`endif
        case (state_q)
            ST_ACCUM: begin
                if (s_valid) begin
                    if (cnt_q[bin_c] == CNT_MAX) begin
                        sat_d = 1'b1;
                    end else begin
                        cnt_d[bin_c] = inc_c;
`ifdef HIST_PEAK_EN
                        if (inc_c > peak_cnt) begin
                            peak_cnt_d = inc_c;
                            peak_bin_d = bin_c;
                        end
`endif
                    end
                end
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    idx_d   = '0;
                end else if (dump_req) begin
                    state_d = ST_DUMP;
                    idx_d   = '0;
                end
            end
            ST_DUMP: begin
                if (m_ready) begin
                    if (CLEAR_ON_READ) cnt_d[idx_q] = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_ACCUM;
                        idx_d   = '0;
                        if (CLEAR_ON_READ) begin
                            sat_d = 1'b0;
`ifdef HIST_PEAK_EN
                            peak_bin_d = '0;
                            peak_cnt_d = '0;
`endif
                        end
                    end else begin
                        idx_d = idx_q + BIN_BITS'(1);
                    end
                end
            end
            ST_CLEAR: begin
                cnt_d[idx_q] = '0;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_ACCUM;
                    idx_d   = '0;
                    sat_d   = 1'b0;
`ifdef HIST_PEAK_EN
                    peak_bin_d = '0;
                    peak_cnt_d = '0;
`endif
                end else begin
                    idx_d = idx_q + BIN_BITS'(1);
                end
            end
            default: begin
                state_d = ST_ACCUM;
                idx_d   = '0;
            end
        endcase
    end

    assign dump_d = (state_d == ST_DUMP);

    // Outputs are registered from next-state so the beat lines up with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_ACCUM;
            idx_q    <= '0;
            for (int i = 0; i < int'(NUM_BINS); i++) cnt_q[i] <= '0;
            sat_flag <= 1'b0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_bin    <= '0;
            m_last   <= 1'b0;
            s_ready  <= 1'b1;
            busy     <= 1'b0;
`ifdef HIST_PEAK_EN
            peak_bin <= '0;
            peak_cnt <= '0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            sat_flag <= sat_d;
            m_valid  <= dump_d;
            m_data   <= dump_d ? cnt_d[idx_d] : '0;
            m_bin    <= dump_d ? idx_d : '0;
            m_last   <= dump_d && (idx_d == LAST_IDX);
            s_ready  <= (state_d == ST_ACCUM);
            busy     <= (state_d != ST_ACCUM);
`ifdef HIST_PEAK_EN
            peak_bin <= peak_bin_d;
            peak_cnt <= peak_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_hist_accum_engine.sv
// Directed self-checking bench for hist_accum_engine (default parameters, clear-on-read).
module tb_hist_accum_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_ready;
    logic        dump_req;
    logic        clr_req;
    logic        m_valid;
    logic [7:0]  m_data;
    logic [3:0]  m_bin;
    logic        m_last;
    logic        m_ready;
    logic        busy;
    logic        sat_flag;
`ifdef HIST_PEAK_EN
    logic [3:0]  peak_bin;
    logic [7:0]  peak_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hist_accum_engine #(
        .DATA_W        (16),
        .BIN_BITS      (4),
        .CNT_W         (8),
        .CLEAR_ON_READ (1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_ready  (s_ready),
        .dump_req (dump_req),
        .clr_req  (clr_req),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_bin    (m_bin),
        .m_last   (m_last),
        .m_ready  (m_ready),
        .busy     (busy),
`ifdef HIST_PEAK_EN
        .peak_bin (peak_bin),
        .peak_cnt (peak_cnt),
`endif
        .sat_flag (sat_flag)
    );

    typedef struct {
        logic [15:0] sa;
        int unsigned na;
        logic [15:0] sb;
        int unsigned nb;
        int unsigned bin_a;
        logic [7:0]  cnt_a;
        int unsigned bin_b;
        logic [7:0]  cnt_b;
        logic        sat;
    } row_t;

    row_t rows [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic send(input logic [15:0] d, input int unsigned n);
        s_data = d;
        for (int unsigned i = 0; i < n; i++) begin
            s_valid = 1'b1;
            tick();
        end
        s_valid = 1'b0;
    endtask

    task automatic zero_exp(output logic [7:0] e [16]);
        for (int i = 0; i < 16; i++) e[i] = 8'd0;
    endtask

    // Full dump: request, optional co-incident sample, optional stall on one bin.
    task automatic do_dump(input string tag, input logic [7:0] e [16], input int stall_bin,
                           input int stall_n, input bit co_valid, input logic [15:0] co_data);
        int w;
        dump_req = 1'b1;
        s_valid  = co_valid;
        s_data   = co_data;
        tick();
        dump_req = 1'b0;
        s_valid  = 1'b0;
        m_ready  = 1'b0;
        for (int b = 0; b < 16; b++) begin
            w = 0;
            while (!m_valid && w < 8) begin
                tick();
                w++;
            end
            chk($sformatf("%s valid b%0d", tag, b), 32'(m_valid), 32'd1);
            chk($sformatf("%s bin b%0d", tag, b), 32'(m_bin), 32'(b));
            chk($sformatf("%s data b%0d", tag, b), 32'(m_data), 32'(e[b]));
            chk($sformatf("%s last b%0d", tag, b), 32'(m_last), 32'(b == 15));
            if (b == stall_bin) begin
                for (int k = 0; k < stall_n; k++) begin
                    tick();
                    chk($sformatf("%s stall valid k%0d", tag, k), 32'(m_valid), 32'd1);
                    chk($sformatf("%s stall bin k%0d", tag, k), 32'(m_bin), 32'(b));
                    chk($sformatf("%s stall data k%0d", tag, k), 32'(m_data), 32'(e[b]));
                end
            end
            m_ready = 1'b1;
            tick();
            m_ready = 1'b0;
        end
        chk({tag, " valid drop"}, 32'(m_valid), 32'd0);
        chk({tag, " busy drop"}, 32'(busy), 32'd0);
        chk({tag, " sat after"}, 32'(sat_flag), 32'd0);
    endtask

    logic [7:0] exp [16];

    initial begin
        rows[0] = '{16'h1234, 3,   16'hF000, 1, 1,  8'd3,   15, 8'd1,   1'b0};
        rows[1] = '{16'h0000, 300, 16'h0000, 0, 0,  8'd255, 0,  8'd255, 1'b1};
        rows[2] = '{16'hABCD, 2,   16'hA000, 5, 10, 8'd7,   10, 8'd7,   1'b0};
        rows[3] = '{16'h7FFF, 255, 16'h8000, 1, 7,  8'd255, 8,  8'd1,   1'b0};
        rows[4] = '{16'h3000, 256, 16'h4000, 2, 3,  8'd255, 4,  8'd2,   1'b1};

        rst_n    = 1'b0;
        s_valid  = 1'b0;
        s_data   = 16'h0;
        dump_req = 1'b0;
        clr_req  = 1'b0;
        m_ready  = 1'b0;
        tick();
        tick();
        chk("rst m_valid", 32'(m_valid), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst sat", 32'(sat_flag), 32'd0);
        chk("rst s_ready", 32'(s_ready), 32'd1);
        chk("rst m_data", 32'(m_data), 32'd0);
        chk("rst m_bin", 32'(m_bin), 32'd0);
        chk("rst m_last", 32'(m_last), 32'd0);
        rst_n = 1'b1;
        tick();

        // Table rows: feed samples, check saturation, then dump and compare every bin.
        for (int r = 0; r < 5; r++) begin
            send(rows[r].sa, rows[r].na);
            send(rows[r].sb, rows[r].nb);
            chk($sformatf("row%0d sat before", r), 32'(sat_flag), 32'(rows[r].sat));
            zero_exp(exp);
            exp[rows[r].bin_a] = rows[r].cnt_a;
            exp[rows[r].bin_b] = rows[r].cnt_b;
            do_dump($sformatf("row%0d", r), exp, -1, 0, 1'b0, 16'h0);
        end

        // Backpressure held at bin 3 for 5 cycles.
        send(16'h3000, 4);
        send(16'h4000, 1);
        zero_exp(exp);
        exp[3] = 8'd4;
        exp[4] = 8'd1;
        do_dump("stall", exp, 3, 5, 1'b0, 16'h0);

        // Sequential clear: 16 busy cycles, samples and dump_req ignored meanwhile.
        send(16'h5000, 10);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int c = 0; c < 16; c++) begin
            chk($sformatf("clr busy c%0d", c), 32'(busy), 32'd1);
            chk($sformatf("clr s_ready c%0d", c), 32'(s_ready), 32'd0);
            s_valid  = (c == 5);
            s_data   = 16'h6000;
            dump_req = (c == 5);
            tick();
        end
        s_valid  = 1'b0;
        dump_req = 1'b0;
        chk("clr exit busy", 32'(busy), 32'd0);
        chk("clr exit s_ready", 32'(s_ready), 32'd1);
        tick();
        chk("clr no queued dump", 32'(m_valid), 32'd0);
        zero_exp(exp);
        do_dump("after clr", exp, -1, 0, 1'b0, 16'h0);

        // Reset asserted mid-dump at bin 7.
        send(16'h9000, 2);
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        for (int b = 0; b < 7; b++) begin
            m_ready = 1'b1;
            tick();
        end
        m_ready = 1'b0;
        chk("mid dump bin", 32'(m_bin), 32'd7);
        chk("mid dump valid", 32'(m_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async rst m_valid", 32'(m_valid), 32'd0);
        chk("async rst busy", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        zero_exp(exp);
        do_dump("after rst", exp, -1, 0, 1'b0, 16'h0);

        // Sample accepted in the same cycle as dump_req is counted.
        zero_exp(exp);
        exp[2] = 8'd1;
        do_dump("co sample", exp, -1, 0, 1'b1, 16'h2000);
        zero_exp(exp);
        do_dump("co second", exp, -1, 0, 1'b0, 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
